// File: rtl/mat_vec_ctrl_pkg.sv
// Shared types and job-layout constants for the mat-vec sequencer.
// Exports the FSM state enum, matrix geometry and the 7-bit byte-index width.
package mat_vec_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    REQ,
    RESP,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } ctrl_state_t;

  localparam int NUM_ROWS   = 8;
  localparam int ROW_LEN    = 8;
  localparam int JOB_BYTES  = NUM_ROWS * ROW_LEN + ROW_LEN;
  localparam int B_BASE_IDX = NUM_ROWS * ROW_LEN;
  localparam int IDX_W      = 7;

endpackage

// File: rtl/mat_vec_ctrl_if.sv
// Memory read port plus result valid/ready bundle for mat_vec_ctrl.
// master = controller side, slave = memory / result consumer side.
interface mat_vec_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  localparam int RES_W = 8 * 3 * DATA_WIDTH;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  res_valid;
  logic                  res_ready;
  logic [RES_W-1:0]      res_data;

  modport master (
    output mem_req, mem_addr, res_valid, res_data,
    input  mem_gnt, mem_rvalid, mem_rdata, res_ready
  );

  modport slave (
    input  mem_req, mem_addr, res_valid, res_data,
    output mem_gnt, mem_rvalid, mem_rdata, res_ready
  );
endinterface

// File: rtl/mat_vec_ctrl.sv
// Job sequencer for the 8x8 mat-vec MAC: clear, fetch 72 bytes, route to
// A-row/B FIFOs, wait for done, hold results. Ports: clk/rst/start/base_addr,
// busy/err status, bus (memory + result handshake), FIFO strobes, Clr, done/out_flat.
module mat_vec_ctrl
  import mat_vec_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  output logic                             busy,
  output logic                             err,
  mat_vec_ctrl_if.master                   bus,
  output logic [NUM_ROWS-1:0]              a_wren,
  output logic [DATA_WIDTH-1:0]            a_fifo_in,
  output logic                             b_wren,
  output logic [DATA_WIDTH-1:0]            b_fifo_in,
  output logic                             Clr,
  input  logic                             done,
  input  logic [NUM_ROWS*3*DATA_WIDTH-1:0] out_flat
);

  localparam int RES_W = NUM_ROWS * 3 * DATA_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  ctrl_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [NUM_ROWS-1:0]   a_wren_q, a_wren_d;
  logic [DATA_WIDTH-1:0] a_in_q, a_in_d;
  logic                  b_wren_q, b_wren_d;
  logic [DATA_WIDTH-1:0] b_in_q, b_in_d;
  logic                  res_valid_q, res_valid_d;
  logic [RES_W-1:0]      res_data_q, res_data_d;
  logic                  tmo;

  assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    a_wren_d    = '0;
    a_in_d      = a_in_q;
    b_wren_d    = 1'b0;
    b_in_d      = b_in_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = CLR;
        end
      end
      CLR: state_d = REQ;
      REQ: begin
        if (bus.mem_gnt) state_d = RESP;
      end
      RESP: begin
        if (bus.mem_rvalid) begin
          if (idx_q < IDX_W'(B_BASE_IDX)) begin
            a_wren_d = NUM_ROWS'(1) << idx_q[5:3];
            a_in_d   = bus.mem_rdata;
          end else begin
            b_wren_d = 1'b1;
            b_in_d   = bus.mem_rdata;
          end
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
          if (idx_q == IDX_W'(JOB_BYTES - 1)) state_d = WAIT_BUSY;
          else state_d = REQ;
        end
      end
      // done may still be high from the previous job; wait for it to fall
      WAIT_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!done) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          res_data_d  = out_flat;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      a_wren_q    <= '0;
      a_in_q      <= '0;
      b_wren_q    <= 1'b0;
      b_in_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      a_wren_q    <= a_wren_d;
      a_in_q      <= a_in_d;
      b_wren_q    <= b_wren_d;
      b_in_q      <= b_in_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign err           = err_q;
  assign Clr           = (state_q == CLR);
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_addr  = base_q + ADDR_WIDTH'(idx_q);
  assign a_wren        = a_wren_q;
  assign a_fifo_in     = a_in_q;
  assign b_wren        = b_wren_q;
  assign b_fifo_in     = b_in_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mat_vec_ctrl.sv
// Bench for mat_vec_ctrl: memory responder, datapath model, scoreboards.
// Job table drives the main flow; timeout and mid-load reset are hand sequences.
module tb_mat_vec_ctrl;
  import mat_vec_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TO = 1024;
  localparam int RW = 8 * 3 * DW;

  typedef struct {
    logic [AW-1:0] base;
    bit            wmode;
    bit            stale;
    bit            keep_done;
    logic [RW-1:0] exp;
  } vec_t;

  typedef struct {
    bit         is_b;
    int         row;
    logic [7:0] d;
  } strb_t;

  logic          clk = 1'b0;
  logic          rst, start, done, busy, err, b_wren, Clr;
  logic [AW-1:0] base_addr;
  logic [7:0]    a_wren;
  logic [DW-1:0] a_fifo_in, b_fifo_in;
  logic [RW-1:0] out_flat;

  always #5 clk = ~clk;

  mat_vec_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mat_vec_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .err(err), .bus(bus),
    .a_wren(a_wren), .a_fifo_in(a_fifo_in),
    .b_wren(b_wren), .b_fifo_in(b_fifo_in),
    .Clr(Clr), .done(done), .out_flat(out_flat)
  );

  int            n_checks, n_errors, cyc;
  int            strobes_seen, t_wb, rv_seen, clr_seen;
  bit            wmode;
  logic [7:0]    mem [0:65535];
  logic [AW-1:0] exp_addr_q [$];
  strb_t         exp_strb_q [$];
  logic [RW-1:0] exp_res_q [$];
  logic [7:0]    af [8][8];
  int            acnt [8];
  logic [7:0]    bf [8];
  int            bcnt;
  vec_t          vecs [4];

  task automatic check(input string nm, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] model(input logic [AW-1:0] b);
    logic [RW-1:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      logic [23:0] acc = '0;
      for (int k = 0; k < 8; k++)
        acc += 24'(mem[b + AW'(8 * i + k)]) * 24'(mem[b + AW'(64 + k)]);
      r[24*i +: 24] = acc;
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] dp_result();
    logic [RW-1:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      logic [23:0] acc = '0;
      for (int k = 0; k < 8; k++)
        acc += 24'(af[i][k]) * 24'(bf[k]);
      r[24*i +: 24] = acc;
    end
    return r;
  endfunction

  task automatic monitor();
    strb_t s;
    if (Clr) begin
      clr_seen++;
      for (int r = 0; r < 8; r++) acnt[r] = 0;
      bcnt = 0;
    end
    if (bus.mem_req) begin
      if (exp_addr_q.size() == 0) check("addr_unexpected_req", 1, 0);
      else check("mem_addr", bus.mem_addr, exp_addr_q[0]);
      if (bus.mem_gnt && exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
    end
    if (a_wren != 0 || b_wren) begin
      check("strobe_onehot", $countones({a_wren, b_wren}), 1);
      strobes_seen++;
      if (strobes_seen == 72) t_wb = cyc;
      if (exp_strb_q.size() == 0) begin
        check("strobe_unexpected", 1, 0);
      end else begin
        s = exp_strb_q.pop_front();
        check("strobe_route",
              {b_wren, a_wren, (b_wren ? b_fifo_in : a_fifo_in)},
              {s.is_b, (s.is_b ? 8'h00 : 8'(8'h01 << s.row)), s.d});
      end
      if (b_wren && bcnt < 8) begin
        bf[bcnt] = b_fifo_in;
        bcnt++;
      end
      for (int r = 0; r < 8; r++)
        if (a_wren[r] && acnt[r] < 8) begin
          af[r][acnt[r]] = a_fifo_in;
          acnt[r]++;
        end
    end
    if (bus.res_valid) rv_seen++;
    if (bus.res_valid && bus.res_ready) begin
      if (exp_res_q.size() == 0) check("res_unexpected", 1, 0);
      else check("res_data_handshake", bus.res_data, exp_res_q.pop_front());
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // memory responder: one request at a time, optional random wait states
  initial begin
    logic [AW-1:0] a;
    int gd, rd;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    @(posedge clk);
    #1;
    forever begin
      if (!bus.mem_req || rst) begin
        @(posedge clk);
        #1;
        continue;
      end
      gd = wmode ? int'($urandom_range(0, 3)) : 0;
      rd = wmode ? int'($urandom_range(1, 4)) : 1;
      repeat (gd) begin @(posedge clk); #1; end
      if (!bus.mem_req) continue;
      a = bus.mem_addr;
      bus.mem_gnt = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_gnt = 1'b0;
      repeat (rd - 1) begin @(posedge clk); #1; end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem[a];
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
    end
  end

  task automatic kick(input logic [AW-1:0] b);
    strb_t s;
    for (int i = 0; i < 72; i++) begin
      exp_addr_q.push_back(b + AW'(i));
      s.is_b = (i >= 64);
      s.row  = i / 8;
      s.d    = mem[b + AW'(i)];
      exp_strb_q.push_back(s);
    end
    strobes_seen = 0;
    clr_seen     = 0;
    base_addr    = b;
    start        = 1'b1;
    step();
    start = 1'b0;
    check("clr_pulse", Clr, 1);
    check("start_busy", busy, 1);
    check("err_cleared", err, 0);
    step();
    check("first_req", bus.mem_req, 1);
    check("clr_single", {Clr, 8'(clr_seen)}, {1'b0, 8'd1});
  endtask

  task automatic wait_load(input int n);
    for (int k = 0; k < 4000 && strobes_seen < n; k++) step();
    check("load_strobes", strobes_seen, n);
  endtask

  task automatic run_job(input vec_t v);
    wmode = v.wmode;
    if (!v.stale) done = 1'b0;
    exp_res_q.push_back(v.exp);
    kick(v.base);
    wait_load(72);
    check("addr_q_drained", exp_addr_q.size(), 0);
    if (v.stale) begin
      repeat (4) step();
      check("stale_busy", busy, 1);
      check("stale_no_valid", bus.res_valid, 0);
      done = 1'b0;
      step();
    end
    repeat (2) step();
    out_flat = dp_result();
    done     = 1'b1;
    step();
    check("res_valid_rise", bus.res_valid, 1);
    out_flat = ~out_flat;
    bus.res_ready = 1'b0;
    repeat (3) begin
      step();
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", bus.res_data, v.exp);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("valid_drop", bus.res_valid, 0);
    check("idle_after_hs", busy, 0);
    if (!v.keep_done) done = 1'b0;
  endtask

  initial begin
    logic [RW-1:0] ident, all48;
    int rv0;
    n_checks = 0; n_errors = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0;
    done = 1'b0; out_flat = '0; bus.res_ready = 1'b0; wmode = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        mem[16'h0100 + 16'(8 * r + k)] = (r == k) ? 8'd1 : 8'd0;
        mem[16'h0200 + 16'(8 * r + k)] = 8'd2;
      end
    for (int k = 0; k < 8; k++) begin
      mem[16'h0140 + 16'(k)] = 8'(k + 1);
      mem[16'h0240 + 16'(k)] = 8'd3;
    end
    for (int i = 0; i < 72; i++) mem[16'hFFF0 + 16'(i)] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      ident[24*i +: 24] = 24'(i + 1);
      all48[24*i +: 24] = 24'd48;
    end
    vecs[0] = '{16'h0100, 1'b0, 1'b0, 1'b0, ident};
    vecs[1] = '{16'h0100, 1'b1, 1'b0, 1'b0, ident};
    vecs[2] = '{16'hFFF0, 1'b0, 1'b0, 1'b1, model(16'hFFF0)};
    vecs[3] = '{16'h0200, 1'b1, 1'b1, 1'b0, all48};

    repeat (3) step();
    check("rst_outputs",
          {busy, err, bus.mem_req, a_wren, b_wren, Clr, bus.res_valid},
          '0);
    check("rst_data", {bus.mem_addr, a_fifo_in, b_fifo_in}, '0);
    check("rst_res_data", bus.res_data, '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) run_job(vecs[i]);

    // timeout: done never rises
    wmode = 1'b0;
    done  = 1'b0;
    rv0   = rv_seen;
    kick(16'h0100);
    wait_load(72);
    for (int k = 0; k < 1200 && busy; k++) step();
    check("timeout_cycles", cyc - t_wb, TO);
    check("timeout_err", err, 1);
    check("timeout_idle", busy, 0);
    check("timeout_no_valid", rv_seen - rv0, 0);

    // reset in the middle of the load
    kick(16'h0100);
    wait_load(30);
    rst   = 1'b1;
    start = 1'b1;
    step();
    check("midrst_outputs",
          {busy, err, bus.mem_req, a_wren, b_wren, Clr, bus.res_valid},
          '0);
    check("midrst_data", {bus.mem_addr, a_fifo_in, b_fifo_in}, '0);
    check("midrst_res_data", bus.res_data, '0);
    step();
    rst   = 1'b0;
    start = 1'b0;
    exp_addr_q.delete();
    exp_strb_q.delete();
    step();
    check("start_ignored_in_rst", busy, 0);
    repeat (3) step();
    run_job(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mat_vec_ctrl.md
# mat_vec_ctrl

Sequencer that sits in front of the 8x8 matrix-vector MAC datapath. On a start command it clears the MAC accumulators and fetches a 72-byte job (8 matrix rows, then the vector) from a byte-wide memory port. It steers each byte into the correct A-row FIFO or the B FIFO, waits for the datapath `done`, then captures the eight 24-bit results and holds them behind a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 8, element width; results are `3*DATA_WIDTH`.
- `ADDR_WIDTH`, 16, memory byte-address width.
- `TIMEOUT`, 1024, max cycles spent in WAIT_BUSY+WAIT_DONE before abort.
- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: job request; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: job base address, latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky timeout flag; cleared on the next accepted `start`.
- `mem_req` out 1, `mem_addr` out ADDR_WIDTH, `mem_gnt` in 1: read-request handshake.
- `mem_rvalid` in 1, `mem_rdata` in DATA_WIDTH: in-order read return.
- `a_wren` out 8, `a_fifo_in` out DATA_WIDTH: one-hot A-row FIFO write.
- `b_wren` out 1, `b_fifo_in` out DATA_WIDTH: B FIFO write.
- `Clr` out 1: accumulator clear pulse to the datapath.
- `done` in 1: datapath completion level.
- `out_flat` in 8*3*DATA_WIDTH: datapath results; row i occupies bits [24i+23:24i] at the default width.
- `res_valid` out 1, `res_ready` in 1, `res_data` out 8*3*DATA_WIDTH: captured results, same packing as `out_flat`.

## Operation
- States:
  - IDLE → CLR → REQ ⇄ RESP → WAIT_BUSY → WAIT_DONE → HOLD → IDLE.
  - Timeout abort path: WAIT_BUSY/WAIT_DONE → IDLE.
- IDLE: `start`=1 latches `base_addr`, zeroes byte index `idx` (7 bits), clears `err`, moves to CLR.
- CLR: `Clr`=1 for exactly this one cycle, then REQ.
- REQ:
  - `mem_req`=1, `mem_addr`=`base+idx` modulo 2^ADDR_WIDTH.
  - On `mem_gnt` go to RESP.
  - Only one request is ever outstanding.
- RESP:
  - On `mem_rvalid`, route the byte:
    - `idx` 0..63: A row `idx[5:3]`.
    - `idx` 64..71: B.
  - Then increment `idx`.
  - `idx`==71 → WAIT_BUSY; otherwise back to REQ.
- Write strobes are registered:
  - `a_wren[r]` or `b_wren` is high for one cycle, the cycle after `mem_rvalid`.
  - `a_fifo_in`/`b_fifo_in` carry the byte during that cycle.
  - Never more than one strobe bit high.
- WAIT_BUSY: advance to WAIT_DONE once `done`==0. This absorbs a `done` still high from the previous job; if `done` is already 0, advance next cycle.
- WAIT_DONE: on `done`==1, register `out_flat` into `res_data`, assert `res_valid`, go to HOLD.
- HOLD: `res_data` is stable. `res_valid && res_ready` → `res_valid` drops next cycle, state IDLE.
- Timeout:
  - A cycle counter runs in WAIT_BUSY/WAIT_DONE.
  - Reaching TIMEOUT sets `err`=1 and returns to IDLE without asserting `res_valid`.
- Ignored inputs:
  - `start` is ignored outside IDLE.
  - `mem_rvalid` is ignored outside RESP.
  - `mem_gnt` is ignored outside REQ.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `err`, `mem_req`, `a_wren`, `b_wren`, `Clr`, `res_valid` = 0.
  - `mem_addr`, `a_fifo_in`, `b_fifo_in`, `res_data` = 0.
- Reset mid-job: all of the above within one cycle. Partially filled FIFOs are the datapath's responsibility.
- `start` at cycle 0:
  - `Clr` high at cycle 1.
  - `mem_req` first high at cycle 2.
- Minimum per byte is 2 cycles: grant in REQ, `mem_rvalid` next cycle in RESP. Minimum load is therefore 144 cycles after CLR.
- `mem_addr` is held constant while `mem_req`=1 and `mem_gnt`=0.
- `mem_rvalid` arriving in the same cycle as `mem_gnt` is illegal; the bench must not drive it.
- `res_valid` rises the cycle after `done` is sampled high.
- `res_ready` held high in HOLD gives a one-cycle `res_valid` pulse.
- Back-to-back jobs: `start` is accepted on the first IDLE cycle after the handshake.

## Structure
- Package `mat_vec_ctrl_pkg` holds:
  - State enum `ctrl_state_t`.
  - Constants `NUM_ROWS`=8, `ROW_LEN`=8, `JOB_BYTES`=72, `B_BASE_IDX`=64.
- Single module, no sub-module. FSM, `idx` counter, timeout counter and result register all live in `mat_vec_ctrl`.

## Test plan
- Identity job:
  - Stimulus: A=I, B={1..8}, base 0x0100, zero-wait memory.
  - Response: `Clr` pulse once; 72 single-bit strobes in order (rows 0..7, then B); `res_data` rows = 1..8; `res_valid` high until `res_ready`.
- Wait-state memory:
  - Stimulus: random 0–3 cycle `mem_gnt` delay and 1–4 cycle `mem_rvalid` delay.
  - Response: `mem_addr` 0x0100..0x0147 strictly sequential; byte routing identical to the zero-wait run.
- Address wrap:
  - Stimulus: `base_addr`=0xFFF0.
  - Response: addresses 0xFFF0..0xFFFF then 0x0000..0x0037.
- Stale `done`:
  - Stimulus: second job started while `done` is still high from job 1.
  - Response: controller stays in WAIT_BUSY until `done` falls; captures only job-2 results, e.g. A all 2s, B all 3s gives every row 48.
- Timeout:
  - Stimulus: `done` held 0 forever.
  - Response: `err`=1 and `busy`=0 exactly TIMEOUT cycles after entering WAIT_BUSY; `res_valid` never asserted; next `start` clears `err`.
- Reset mid-load:
  - Stimulus: `rst` asserted at byte 30.
  - Response: all outputs 0 the next cycle; ignored `start` during reset; a fresh job afterward completes correctly.
